// File: rtl/comb_lab_pkg.sv
// rtl/comb_lab_pkg.sv - shared types, defaults and decode helper for the dispatch lab
`timescale 1ns/1ps
package comb_lab_pkg;

  localparam int DEF_IDX_W   = 2;
  localparam int DEF_TIMEOUT = 8;
  localparam int MAX_IDX_W   = 5;
  localparam int MAX_LINES   = 2 ** MAX_IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Callers cast the result down to their own line count.
  function automatic logic [MAX_LINES-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_LINES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - saturating wait counter with clear, enable and terminal-count flag
`timescale 1ns/1ps
module wait_timer #(
  parameter int LIMIT = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // LIMIT of zero disables the timer: the count stays at zero and tc never fires.
  localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT > 0) ? (LIMIT - 1) : 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (LIMIT != 0) && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (LIMIT != 0) && (cnt == LAST);

endmodule

// File: rtl/decoder_2to4_dispatch.sv
// rtl/decoder_2to4_dispatch.sv - index-to-one-hot request dispatcher with ack/timeout handshake
`timescale 1ns/1ps
module decoder_2to4_dispatch
  import comb_lab_pkg::*;
#(
  parameter  int IDX_W   = DEF_IDX_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int N       = 2 ** IDX_W,
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     y,
  input  logic [N-1:0]     ack,
  output logic             done,
  output logic             timeout,
  output logic             err,
  input  logic             err_clr
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     y_q, y_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic             err_set;

  wait_timer #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      y_q       <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      y_q       <= y_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  // While busy y_q is the one-hot of idx_q, so any ack outside it is a wrong-line ack.
  assign err_set = (state_q == IDLE) ? (|ack) : (|(ack & ~y_q));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    y_d       = y_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          idx_d   = in;
          y_d     = N'(onehot(MAX_IDX_W'(in)));
          tmr_clr = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        tmr_en = 1'b1;
        if (ack[idx_q]) begin
          y_d     = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmr_tc) begin
          y_d       = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        y_d     = '0;
        state_d = IDLE;
      end
    endcase

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign y        = y_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign err      = err_q;

endmodule

// File: tb/tb_decoder_2to4_dispatch.sv
// tb/tb_decoder_2to4_dispatch.sv - scoreboard bench for decoder_2to4_dispatch
`timescale 1ns/1ps
module tb_decoder_2to4_dispatch;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] din      = 2'b00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] y;
  logic [3:0] ack      = 4'b0000;
  logic       done;
  logic       timeout;
  logic       err;
  logic       err_clr  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] y;
    logic       to;
    int         len;
  } exp_t;

  exp_t       sb[$];
  int         run_len = 0;
  logic [3:0] run_y   = 4'b0000;

  always #5 clk = ~clk;

  decoder_2to4_dispatch #(
    .IDX_W   (2),
    .TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .ack      (ack),
    .done     (done),
    .timeout  (timeout),
    .err      (err),
    .err_clr  (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] ey, input logic eto, input int elen);
    exp_t e;
    e.y   = ey;
    e.to  = eto;
    e.len = elen;
    sb.push_back(e);
  endtask

  task automatic accept(input int i);
    int budget;
    budget = 20;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    din      = 2'(i);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("accept_y", 32'(y), 32'(oh(i)));
    check("busy_ready", 32'(in_ready), 32'd0);
  endtask

  // Tracks each request's held value and length, retires it on done/timeout.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      check("onehot", 32'($countones(y) <= 1), 32'd1);
      if (done || timeout) begin
        check("excl", 32'(done && timeout), 32'd0);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_y", 32'(run_y), 32'(e.y));
          check("sb_kind", 32'(timeout), 32'(e.to));
          check("sb_len", 32'(run_len), 32'(e.len));
        end
        run_len = 0;
      end else if (y != 4'b0000) begin
        run_len++;
        run_y = y;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_y", 32'(y), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);

    // reset mid-request
    accept(2);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_y_after", 32'(y), 32'd0);

    // normal dispatch
    push(4'b0100, 1'b0, 2);
    accept(2);
    tick();
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    check("norm_y", 32'(y), 32'd0);
    check("norm_done", 32'(done), 32'd1);
    check("norm_timeout", 32'(timeout), 32'd0);
    check("norm_ready", 32'(in_ready), 32'd1);
    tick();
    check("norm_done_pulse", 32'(done), 32'd0);

    // timeout
    push(4'b1000, 1'b1, 8);
    accept(3);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("to_hold_y", 32'(y), 32'h8);
      check("to_hold_pulse", 32'(timeout), 32'd0);
    end
    tick();
    check("to_y", 32'(y), 32'd0);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_done", 32'(done), 32'd0);
    tick();
    check("to_pulse", 32'(timeout), 32'd0);

    // ack coincides with the last allowed cycle
    push(4'b0001, 1'b0, 8);
    accept(0);
    for (int k = 0; k < 7; k++) tick();
    ack = 4'b0001;
    tick();
    ack = 4'b0000;
    check("sim_done", 32'(done), 32'd1);
    check("sim_timeout", 32'(timeout), 32'd0);
    check("sim_y", 32'(y), 32'd0);
    tick();

    // wrong and spurious acks
    push(4'b0010, 1'b0, 2);
    accept(1);
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    check("wrong_y", 32'(y), 32'h2);
    check("wrong_err", 32'(err), 32'd1);
    check("wrong_done", 32'(done), 32'd0);
    ack = 4'b0010;
    tick();
    ack = 4'b0000;
    check("wrong_then_done", 32'(done), 32'd1);
    check("wrong_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);
    ack = 4'b1000;
    tick();
    ack = 4'b0000;
    check("idle_spurious", 32'(err), 32'd1);
    ack     = 4'b0001;
    err_clr = 1'b1;
    tick();
    ack     = 4'b0000;
    err_clr = 1'b0;
    check("err_set_wins", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr2", 32'(err), 32'd0);

    // back-to-back with in_valid held during busy
    push(4'b1000, 1'b0, 3);
    push(4'b0010, 1'b0, 1);
    accept(3);
    din      = 2'b01;
    in_valid = 1'b1;
    tick();
    tick();
    check("b2b_hold_y", 32'(y), 32'h8);
    check("b2b_busy", 32'(in_ready), 32'd0);
    ack = 4'b1000;
    tick();
    ack = 4'b0000;
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_y0", 32'(y), 32'd0);
    check("b2b_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_next_y", 32'(y), 32'h2);
    ack = 4'b0010;
    tick();
    ack = 4'b0000;
    check("b2b_done2", 32'(done), 32'd1);
    tick();

    // one-hot sweep
    for (int i = 0; i < 4; i++) begin
      push(oh(i), 1'b0, 1);
      accept(i);
      ack = oh(i);
      tick();
      ack = 4'b0000;
      check("sweep_done", 32'(done), 32'd1);
      tick();
    end

    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
